// File: rtl/ex_muldiv_iter_pkg.sv
// Shared op codes, FSM states and small decode helpers for the iterative mul/div unit.
package ex_muldiv_iter_pkg;

   localparam int MD_DATA_W = 32;
   localparam int MD_CNT_W  = 6;

   // bit2 = accumulate, bit1 = subtract/div, bit0 = unsigned
   typedef enum logic [2:0] {
      MD_OP_MULT  = 3'b000,
      MD_OP_MULTU = 3'b001,
      MD_OP_DIV   = 3'b010,
      MD_OP_DIVU  = 3'b011,
      MD_OP_MADD  = 3'b100,
      MD_OP_MADDU = 3'b101,
      MD_OP_MSUB  = 3'b110,
      MD_OP_MSUBU = 3'b111
   } md_op_e;

   typedef enum logic [2:0] {
      MD_IDLE = 3'd0,
      MD_MUL  = 3'd1,
      MD_DIV  = 3'd2,
      MD_FIX  = 3'd3,
      MD_DIVZ = 3'd4,
      MD_DONE = 3'd5
   } md_state_e;

   function automatic logic md_is_div(input logic [2:0] op);
      return (op[2:1] == 2'b01);
   endfunction

endpackage

// File: rtl/ex_muldiv_iter_if.sv
// EX-side request/result bundle for the iterative multiply/divide unit.
interface ex_muldiv_iter_if #(parameter int DATA_W = 32);
   logic              start_i;
   logic              annul_i;
   logic [2:0]        op_i;
   logic [DATA_W-1:0] opdata1_i;
   logic [DATA_W-1:0] opdata2_i;
   logic [DATA_W-1:0] hi_i;
   logic [DATA_W-1:0] lo_i;
   logic              stall_o;
   logic              ready_o;
   logic              whilo_o;
   logic [DATA_W-1:0] hi_o;
   logic [DATA_W-1:0] lo_o;

   modport master (
      output start_i, annul_i, op_i, opdata1_i, opdata2_i, hi_i, lo_i,
      input  stall_o, ready_o, whilo_o, hi_o, lo_o
   );

   modport slave (
      input  start_i, annul_i, op_i, opdata1_i, opdata2_i, hi_i, lo_i,
      output stall_o, ready_o, whilo_o, hi_o, lo_o
   );
endinterface

// File: rtl/ex_muldiv_iter_div_radix2_core.sv
// One restoring radix-2 division step: shift in a dividend bit, trial-subtract the divisor.
module div_radix2_core
   import ex_muldiv_iter_pkg::*;
#(
   parameter int DATA_W = MD_DATA_W
) (
   input  logic [DATA_W-1:0] i_rem,
   input  logic              i_bit,
   input  logic [DATA_W-1:0] i_div,
   output logic [DATA_W-1:0] o_rem,
   output logic              o_q
);

   logic [DATA_W:0]   w_shift;
   logic [DATA_W+1:0] w_diff;

   assign w_shift = {i_rem, i_bit};
   assign w_diff  = {1'b0, w_shift} - {2'b00, i_div};
   // Partial remainder stays below the divisor, so a successful trial never reaches bit DATA_W.
   assign o_q     = (w_diff[DATA_W+1:DATA_W] == 2'b00);
   assign o_rem   = o_q ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];

endmodule

// File: rtl/ex_muldiv_iter.sv
// Iterative multiply / divide / multiply-accumulate unit beside EX; one bit per cycle.
//
// state   | meaning
// IDLE    | waiting for start_i; latches operands, signs and accumulator
// MUL     | shift-add step, DATA_W cycles
// DIV     | restoring divide step, DATA_W cycles
// FIX     | sign correction and MADD/MSUB accumulate
// DIVZ    | divide-by-zero shortcut result
// DONE    | one-cycle result strobe
module ex_muldiv_iter
   import ex_muldiv_iter_pkg::*;
#(
   parameter int DATA_W = MD_DATA_W,
   parameter int CNT_W  = MD_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   ex_muldiv_iter_if.slave  md
);

   md_state_e           r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [2*DATA_W-1:0] r_sr;
   logic [2*DATA_W-1:0] r_acc;
   logic [DATA_W-1:0]   r_a;
   logic [2:0]          r_op;
   logic                r_neg_q;
   logic                r_neg_r;

   logic                w_stall, w_ready, w_go;
   logic                w_s1, w_s2;
   logic [DATA_W-1:0]   w_mag1, w_mag2;
   logic [DATA_W:0]     w_mul_sum;
   logic [DATA_W-1:0]   w_div_rem;
   logic                w_div_q;
   logic [2*DATA_W-1:0] w_prod, w_result;
   logic [DATA_W-1:0]   w_quot, w_rem;

   assign w_go   = md.start_i & ~md.annul_i;
   assign w_s1   = ~md.op_i[0] & md.opdata1_i[DATA_W-1];
   assign w_s2   = ~md.op_i[0] & md.opdata2_i[DATA_W-1];
   assign w_mag1 = w_s1 ? -md.opdata1_i : md.opdata1_i;
   assign w_mag2 = w_s2 ? -md.opdata2_i : md.opdata2_i;

   assign w_mul_sum = {1'b0, r_sr[2*DATA_W-1:DATA_W]} + {1'b0, (r_sr[0] ? r_a : {DATA_W{1'b0}})};

   div_radix2_core #(.DATA_W(DATA_W)) u_div_step (
      .i_rem (r_sr[2*DATA_W-1:DATA_W]),
      .i_bit (r_sr[DATA_W-1]),
      .i_div (r_a),
      .o_rem (w_div_rem),
      .o_q   (w_div_q)
   );

   assign w_prod = r_neg_q ? -r_sr : r_sr;
   assign w_quot = r_neg_q ? -r_sr[DATA_W-1:0] : r_sr[DATA_W-1:0];
   assign w_rem  = r_neg_r ? -r_sr[2*DATA_W-1:DATA_W] : r_sr[2*DATA_W-1:DATA_W];

   always_comb begin
      w_result = w_prod;
      if (md_is_div(r_op))
         w_result = {w_rem, w_quot};
      else if (r_op[2])
         w_result = r_op[1] ? (r_acc - w_prod) : (r_acc + w_prod);
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= MD_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_ready     = 1'b0;
      case (r_state)
         MD_IDLE: begin
            w_stall = w_go;
            if (w_go) begin
               if (!md_is_div(md.op_i))            w_state_nxt = MD_MUL;
               else if (md.opdata2_i == '0)        w_state_nxt = MD_DIVZ;
               else                                w_state_nxt = MD_DIV;
            end
         end
         MD_MUL, MD_DIV: begin
            w_stall = 1'b1;
            if (r_cnt == '0) w_state_nxt = MD_FIX;
         end
         MD_FIX, MD_DIVZ: begin
            w_stall     = 1'b1;
            w_state_nxt = MD_DONE;
         end
         MD_DONE: begin
            w_ready     = ~md.annul_i;
            w_state_nxt = MD_IDLE;
         end
         default: w_state_nxt = MD_IDLE;
      endcase
      if (r_state != MD_IDLE && md.annul_i) w_state_nxt = MD_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_sr    <= '0;
         r_acc   <= '0;
         r_a     <= '0;
         r_op    <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else begin
         case (r_state)
            MD_IDLE: if (w_go) begin
               r_op    <= md.op_i;
               r_acc   <= {md.hi_i, md.lo_i};
               r_cnt   <= CNT_W'(DATA_W-1);
               r_neg_q <= w_s1 ^ w_s2;
               if (md_is_div(md.op_i)) begin
                  r_a     <= w_mag2;
                  r_neg_r <= w_s1;
                  r_sr    <= (md.opdata2_i == '0) ? {md.opdata1_i, {DATA_W{1'b1}}}
                                                  : {{DATA_W{1'b0}}, w_mag1};
               end else begin
                  r_a     <= w_mag1;
                  r_neg_r <= 1'b0;
                  r_sr    <= {{DATA_W{1'b0}}, w_mag2};
               end
            end
            MD_MUL: begin
               r_sr <= {w_mul_sum, r_sr[DATA_W-1:1]};
               if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            end
            MD_DIV: begin
               r_sr <= {w_div_rem, r_sr[DATA_W-2:0], w_div_q};
               if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            end
            MD_FIX: r_sr <= w_result;
            default: ;
         endcase
      end
   end

   assign md.stall_o = w_stall;
   assign md.ready_o = w_ready;
   assign md.whilo_o = w_ready;
   assign md.hi_o    = w_ready ? r_sr[2*DATA_W-1:DATA_W] : '0;
   assign md.lo_o    = w_ready ? r_sr[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Randomized + directed bench for ex_muldiv_iter against a plain-arithmetic reference model.
module tb_ex_muldiv_iter;
   import ex_muldiv_iter_pkg::*;

   logic clk;
   logic rst;
   int   cyc;
   int   n_tests;
   int   n_fail;

   ex_muldiv_iter_if #(.DATA_W(32)) mdif ();

   ex_muldiv_iter #(.DATA_W(32), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .md  (mdif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // expectation window for the transaction in flight
   logic        chk_en;
   logic        exp_on;
   int          exp_start;
   int          exp_ready;
   int          exp_stall_end;
   logic [31:0] exp_hi;
   logic [31:0] exp_lo;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] h,
                                         input logic [31:0] l);
      longint      sa, sb, q, r;
      logic [63:0] ua, ub, acc;
      sa  = $signed(a);
      sb  = $signed(b);
      ua  = {32'h0, a};
      ub  = {32'h0, b};
      acc = {h, l};
      case (op)
         3'd0: return sa * sb;
         3'd1: return ua * ub;
         3'd2: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         3'd3: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         3'd4: return acc + sa * sb;
         3'd5: return acc + ua * ub;
         3'd6: return acc - sa * sb;
         default: return acc - ua * ub;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] op, input logic [31:0] b);
      return (op[2:1] == 2'b01 && b == 0) ? 2 : 34;
   endfunction

   // single per-cycle compare process
   always @(negedge clk) begin
      if (chk_en) begin
         logic e_rdy, e_stall;
         e_rdy   = exp_on && (cyc == exp_ready);
         e_stall = exp_on && (cyc >= exp_start) && (cyc < exp_stall_end);
         chk("ready_o", 64'(mdif.ready_o), 64'(e_rdy));
         chk("whilo_o", 64'(mdif.whilo_o), 64'(e_rdy));
         chk("stall_o", 64'(mdif.stall_o), 64'(e_stall));
         chk("hi_o", 64'(mdif.hi_o), 64'(e_rdy ? exp_hi : 32'h0));
         chk("lo_o", 64'(mdif.lo_o), 64'(e_rdy ? exp_lo : 32'h0));
      end
   end

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l,
                         input int annul_at, input int rst_at, input int ign_at);
      logic [63:0] res;
      int          lat, kend;
      @(posedge clk); #1;
      res = model(op, a, b, h, l);
      lat = model_lat(op, b);
      rst             = 1'b0;
      mdif.annul_i    = 1'b0;
      mdif.start_i    = 1'b1;
      mdif.op_i       = op;
      mdif.opdata1_i  = a;
      mdif.opdata2_i  = b;
      mdif.hi_i       = h;
      mdif.lo_i       = l;
      exp_hi          = res[63:32];
      exp_lo          = res[31:0];
      exp_start       = cyc;
      exp_ready       = cyc + lat;
      exp_stall_end   = cyc + lat;
      kend            = lat + 1;
      if (annul_at > 0 && annul_at < lat) begin
         exp_ready     = -1;
         exp_stall_end = cyc + annul_at + 1;
         kend          = annul_at + 1;
      end else if (annul_at == lat) begin
         exp_ready = -1;
      end
      if (rst_at > 0) begin
         exp_ready     = -1;
         exp_stall_end = cyc + rst_at + 1;
         kend          = rst_at + 1;
      end
      exp_on = 1'b1;
      for (int k = 1; k < kend; k++) begin
         @(posedge clk); #1;
         mdif.start_i   = (k == ign_at);
         mdif.op_i      = 3'($urandom);
         mdif.opdata1_i = $urandom;
         mdif.opdata2_i = $urandom;
         mdif.hi_i      = $urandom;
         mdif.lo_i      = $urandom;
         mdif.annul_i   = (k == annul_at);
         rst            = (k == rst_at);
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      cyc            = 0;
      n_tests        = 0;
      n_fail         = 0;
      chk_en         = 1'b0;
      exp_on         = 1'b0;
      exp_start      = 0;
      exp_ready      = -1;
      exp_stall_end  = 0;
      exp_hi         = '0;
      exp_lo         = '0;
      rst            = 1'b1;
      mdif.start_i   = 1'b0;
      mdif.annul_i   = 1'b0;
      mdif.op_i      = '0;
      mdif.opdata1_i = '0;
      mdif.opdata2_i = '0;
      mdif.hi_i      = '0;
      mdif.lo_i      = '0;

      // pin the reference model to hand-computed results
      chk("model_mult",  model(MD_OP_MULT,  32'hFFFF_FFFE, 32'h3, 0, 0), 64'hFFFF_FFFF_FFFF_FFFA);
      chk("model_multu", model(MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0), 64'hFFFF_FFFE_0000_0001);
      chk("model_div",   model(MD_OP_DIV,   32'hFFFF_FFF9, 32'h2, 0, 0), 64'hFFFF_FFFF_FFFF_FFFD);
      chk("model_divu",  model(MD_OP_DIVU,  32'd100, 32'd7, 0, 0), {32'd2, 32'd14});
      chk("model_divmin", model(MD_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0), 64'h0000_0000_8000_0000);
      chk("model_divz",  model(MD_OP_DIVU,  32'd5, 32'd0, 0, 0), 64'h0000_0005_FFFF_FFFF);
      chk("model_madd",  model(MD_OP_MADD,  32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF), 64'h0000_0001_0000_0000);
      chk("model_msubu", model(MD_OP_MSUBU, 32'd1, 32'd1, 32'h0, 32'h0), 64'hFFFF_FFFF_FFFF_FFFF);

      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);

      run_op(MD_OP_MULT,  32'hFFFF_FFFE, 32'h3, 32'h1234, 32'h5678, 0, 0, 0);
      run_op(MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 3);
      run_op(MD_OP_DIV,   32'hFFFF_FFF9, 32'h2, 0, 0, 0, 0, 0);
      run_op(MD_OP_DIVU,  32'd100, 32'd7, 0, 0, 0, 0, 0);
      run_op(MD_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
      run_op(MD_OP_DIVU,  32'd5, 32'd0, 0, 0, 0, 0, 0);
      run_op(MD_OP_MADD,  32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 0, 0, 0);
      run_op(MD_OP_MSUBU, 32'd1, 32'd1, 32'h0, 32'h0, 0, 0, 0);
      run_op(MD_OP_DIV,   32'd1000, 32'd3, 0, 0, 10, 0, 0);
      run_op(MD_OP_MULTU, 32'd12345, 32'd678, 0, 0, 0, 0, 0);
      run_op(MD_OP_MULT,  32'd7, 32'd9, 0, 0, 0, 5, 0);
      run_op(MD_OP_MSUB,  32'hFFFF_FFFD, 32'd4, 32'd2, 32'd3, 0, 0, 0);
      run_op(MD_OP_DIVU,  32'd9, 32'd4, 0, 0, 34, 0, 0);
      run_op(MD_OP_DIV,   32'd9, 32'd0, 0, 0, 1, 0, 0);

      for (int i = 0; i < 150; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         int          lat, an, ig;
         op  = 3'($urandom_range(0, 7));
         a   = pick();
         b   = pick();
         lat = model_lat(op, b);
         an  = 0;
         ig  = 0;
         if ($urandom_range(0, 7) == 0)      an = $urandom_range(1, lat);
         else if ($urandom_range(0, 5) == 0) ig = $urandom_range(1, lat - 1);
         run_op(op, a, b, $urandom, $urandom, an, 0, ig);
      end

      @(posedge clk); #1;
      mdif.start_i = 1'b0;
      mdif.annul_i = 1'b0;
      rst          = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
